uart_tx_buf: RTL and testbench

Buffered, parametrised UART transmitter for the accelerator's host link. It accepts words over a valid/ready stream into an internal FIFO and serialises them LSB-first with configurable data width, stop bits and optional parity. Back-to-back frames are sent with no idle gap, and every bit lasts exactly `BIT_TICKS` cycles. It sits between the result-readout logic and the FPGA TX pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync_fifo.sv | 38 +++
 rtl/uart_tx_buf.sv | 113 +++++++++++
 tb/tb_uart_tx_buf.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding and parity-mode values
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered LSB-first UART transmitter; parity frames exist only with UART_TX_PARITY_EN
module uart_tx_buf #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                    parity_mode,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  import uart_pkg::*;
  localparam int BIT_TICKS = CLOCK_FREQ / BAUD;
  localparam int TW = $clog2(STOP_BITS * BIT_TICKS);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * BIT_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  uart_tx_state_t state;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_reg, head;
  logic full, empty, pop, tick_done;
`ifdef UART_TX_PARITY_EN
  logic par_en, par_bit;
`endif
  assign tick_done = tick_cnt == '0;
  assign pop = !empty && (state == IDLE || (state == STOP && tick_done));
  assign s_ready = !full;
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(s_valid), .push_data(s_data), .pop(pop),
    .pop_data(head), .full(full), .empty(empty), .count(fifo_count)
  );
  // tx is driven from the current state, so the line trails the FSM by one cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      busy <= 1'b0;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      par_en <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else begin
      tx <= 1'b1;
      busy <= 1'b1;
      if (pop) begin
        state <= START;
        shift_reg <= head;
        tick_cnt <= BIT_LAST;
`ifdef UART_TX_PARITY_EN
        par_en <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
        par_bit <= ^head ^ (parity_mode == PAR_ODD);
`endif
      end
      case (state)
        IDLE: busy <= !empty;
        START: begin
          tx <= 1'b0;
          tick_cnt <= tick_done ? BIT_LAST : tick_cnt - TW'(1);
          if (tick_done) begin
            state <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          tx <= shift_reg[0];
          if (!tick_done) tick_cnt <= tick_cnt - TW'(1);
          else begin
            shift_reg <= shift_reg >> 1;
            bit_cnt <= bit_cnt + BW'(1);
            tick_cnt <= BIT_LAST;
            if (bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= par_en ? PARITY : STOP;
              tick_cnt <= par_en ? BIT_LAST : STOP_LAST;
`else
              state <= STOP;
              tick_cnt <= STOP_LAST;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par_bit;
          tick_cnt <= tick_done ? STOP_LAST : tick_cnt - TW'(1);
          if (tick_done) state <= STOP;
        end
`endif
        STOP: begin
          if (!tick_done) tick_cnt <= tick_cnt - TW'(1);
          else begin
            busy <= !empty;
            if (empty) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed stimulus with a serial-line decoder checking frames against an expected-word queue
module tb_uart_tx_buf;
  typedef struct packed {logic [7:0] d; logic p_en; logic p;} exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] s_data;
  logic s_valid, s_ready, tx, busy;
  logic [4:0] fifo_count;
  logic [1:0] pm_drv;
  logic [6:0] s_data2;
  logic s_valid2, s_ready2, tx2, busy2;
  logic [4:0] fifo_count2;
  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  exp_t cur;
  int cyc = 0, flen = 100, gap = 1000, frames = 0, b2b = 0;
  logic prev_tx = 1'b1, in_frame = 1'b0, uniform = 1'b1;
  logic [10:0] bits, exp_bits;
  int f0, b0, fc, rc, t, k, f, bf, mism;
  logic wave [130];
  logic bz [130];
  logic [9:0] exp7;
  always #5 clk = ~clk;
  uart_tx_buf #(.CLOCK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pm_drv),
`endif
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );
  uart_tx_buf #(.CLOCK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
`ifdef UART_TX_PARITY_EN
    .parity_mode(2'b00),
`endif
    .tx(tx2), .busy(busy2), .fifo_count(fifo_count2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic logic par_on(input logic [1:0] pm);
`ifdef UART_TX_PARITY_EN
    return pm == 2'b01 || pm == 2'b10;
`else
    return pm[0] & 1'b0;
`endif
  endfunction
  function automatic logic par_calc(input logic [7:0] d, input logic [1:0] pm);
    return (pm == 2'b10) ? ~^d : ^d;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      gap = 1000;
    end else if (!in_frame) begin
      if (prev_tx && !tx) begin
        in_frame = 1'b1;
        cyc = 1;
        bits = '1;
        bits[0] = tx;
        uniform = 1'b1;
        if (gap == 0) b2b++;
        chk("frame_expected", q.size() != 0, 1);
        if (q.size() != 0) cur = q.pop_front();
        else cur = '0;
        flen = cur.p_en ? 110 : 100;
      end else gap++;
    end else begin
      if (cyc % 10 == 0) bits[cyc/10] = tx;
      else if (tx !== bits[cyc/10]) uniform = 1'b0;
      cyc++;
      if (cyc == flen) begin
        in_frame = 1'b0;
        gap = 0;
        frames++;
        exp_bits = cur.p_en ? {1'b1, cur.p, cur.d, 1'b0} : {2'b11, cur.d, 1'b0};
        chk("frame_bits", bits, exp_bits);
        chk("bit_width", uniform, 1);
      end
    end
    prev_tx = tx;
  end
  task automatic push1(input logic [7:0] d, input logic [1:0] pm);
    int n = 0;
    @(negedge clk);
    s_data = d;
    s_valid = 1'b1;
    pm_drv = pm;
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", n < 500, 1);
    q.push_back('{d, par_on(pm), par_calc(d, pm)});
    @(negedge clk);
    s_valid = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 3000, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic burst(input int n, input logic [7:0] base, output int full_cnt, output int rise_cnt);
    int acc = 0, tt = 0;
    logic saw_full = 1'b0, saw_rise = 1'b0;
    full_cnt = -1;
    rise_cnt = -1;
    pm_drv = 2'b00;
    @(negedge clk);
    while (acc < n && tt < 5000) begin
      s_data = base + 8'(acc);
      s_valid = 1'b1;
      if (s_ready) begin
        if (saw_full && !saw_rise) begin
          saw_rise = 1'b1;
          rise_cnt = int'(fifo_count);
        end
        q.push_back('{s_data, 1'b0, 1'b0});
        acc++;
      end else if (!saw_full) begin
        saw_full = 1'b1;
        full_cnt = int'(fifo_count);
      end
      @(negedge clk);
      tt++;
    end
    s_valid = 1'b0;
    chk("burst_accept", acc, n);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_valid2 = 1'b0; s_data2 = '0; pm_drv = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_tx2", tx2, 1);
    chk("rst_ready2", s_ready2, 1);
    chk("rst_count2", fifo_count2, 0);
    rst = 1'b0;
    @(negedge clk);
    s_data = 8'hA5;
    s_valid = 1'b1;
    q.push_back('{8'hA5, 1'b0, 1'b0});
    @(negedge clk);
    s_valid = 1'b0;
    chk("lat_n_tx", tx, 1);
    chk("lat_n_busy", busy, 0);
    chk("lat_n_count", fifo_count, 1);
    @(negedge clk);
    chk("lat_n1_tx", tx, 1);
    chk("lat_n1_busy", busy, 1);
    chk("lat_n1_count", fifo_count, 0);
    @(negedge clk);
    chk("lat_n2_tx", tx, 0);
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("a5_busy_len", k, 99);
    repeat (3) @(negedge clk);
    chk("a5_frames", frames, 1);
    f0 = frames;
    b0 = b2b;
    burst(20, 8'h30, fc, rc);
    chk("burst_full_at", fc, 16);
    chk("burst_ready_back", rc, 15);
    wait_idle(t);
    chk("burst_frames", frames - f0, 20);
    chk("burst_contiguous", b2b - b0, 19);
    chk("burst_q_empty", q.size(), 0);
    f0 = frames;
    burst(17, 8'h80, fc, rc);
    chk("full_ready", s_ready, 0);
    chk("full_count", fifo_count, 16);
    s_data = 8'hEE;
    s_valid = 1'b1;
    t = 0;
    while (fifo_count == 16 && t < 300) begin
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
    chk("full_pop_count", fifo_count, 15);
    chk("full_pop_ready", s_ready, 1);
    wait_idle(t);
    chk("full_frames", frames - f0, 17);
    burst(4, 8'hC0, fc, rc);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    f0 = frames;
    push1(8'h3C, 2'b00);
    wait_idle(t);
    chk("post_rst_len", t, 99);
    chk("post_rst_frames", frames - f0, 1);
`ifdef UART_TX_PARITY_EN
    f0 = frames;
    push1(8'h07, 2'b01);
    wait_idle(t);
    chk("par_even_len", t, 109);
    push1(8'h07, 2'b10);
    repeat (20) @(negedge clk);
    pm_drv = 2'b01;
    wait_idle(t);
    chk("par_odd_len", t, 109);
    push1(8'h00, 2'b01);
    wait_idle(t);
    chk("par_zero_len", t, 109);
    chk("par_frames", frames - f0, 3);
    pm_drv = 2'b00;
`endif
    exp7 = {2'b11, 7'h55, 1'b0};
    @(negedge clk);
    s_data2 = 7'h55;
    s_valid2 = 1'b1;
    @(negedge clk);
    s_valid2 = 1'b0;
    for (int j = 0; j < 130; j++) begin
      @(negedge clk);
      wave[j] = tx2;
      bz[j] = busy2;
    end
    f = -1;
    for (int j = 0; j < 130; j++) if (f < 0 && wave[j] == 1'b0) f = j;
    chk("d7_fall", f, 1);
    if (f < 0 || f > 29) f = 0;
    mism = 0;
    for (int j = 0; j < 100; j++) if (wave[f+j] !== exp7[j/10]) mism++;
    chk("d7_wave_mismatches", mism, 0);
    bf = -1;
    for (int j = f; j < 130; j++) if (bf < 0 && !bz[j]) bf = j;
    chk("d7_busy_len", bf - f, 99);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
